// File: rtl/sram_responder.sv
// sram_responder: CPU bus target driving an external async 8-bit SRAM with registered strobes.
// Latency: o_ack in cycle n+3+WAIT_CYCLES after i_cs is first seen in cycle n (n+1 for bank register).
// Backpressure: the initiator holds i_cs/i_addr/i_dat until o_ack; requests arriving mid-access are ignored.
// Optional bank register compiled in with `define SRAM_RESPONDER_BANK_EN.
module sram_responder #(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [15:0] BANK_ADDR   = 16'hFFFF
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_dat,
   output logic [7:0]  o_dat,
   input  logic        i_we,
   input  logic        i_cs,
   output logic        o_ack,
   output logic [17:0] o_sram_addr,
   output logic [7:0]  o_sram_dat,
   output logic        o_sram_dat_oe,
   input  logic [7:0]  i_sram_dat,
   output logic        o_sram_cs_n,
   output logic        o_sram_oe_n,
   output logic        o_sram_we_n
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ack_q, ack_d;
   logic [7:0]  rdat_q, rdat_d;
   logic [17:0] saddr_q, saddr_d;
   logic [7:0]  sdat_q, sdat_d;
   logic        doe_q, doe_d;
   logic        cs_n_q, cs_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;

   logic        is_bank;
   logic [17:0] mapped_addr;

`ifdef SRAM_RESPONDER_BANK_EN
   logic [1:0]  bank_q, bank_d;

   // Upper 32K of the CPU space is windowed by the bank register; lower 32K is fixed.
   assign is_bank     = (i_addr == BANK_ADDR);
   assign mapped_addr = i_addr[15] ? {bank_q, i_addr} : {2'b00, i_addr};
`else
   logic        unused_bank_addr;

   // Without banking every CPU address, BANK_ADDR included, is plain SRAM.
   assign is_bank          = 1'b0;
   assign mapped_addr      = {2'b00, i_addr};
   assign unused_bank_addr = ^BANK_ADDR;
`endif

   // Next-state and next-output logic; every SRAM-side output is the register written here.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      rdat_d  = rdat_q;
      saddr_d = saddr_q;
      sdat_d  = sdat_q;
      doe_d   = doe_q;
      cs_n_d  = cs_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
`ifdef SRAM_RESPONDER_BANK_EN
      bank_d  = bank_q;
`endif
      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            oe_n_d = 1'b1;
            we_n_d = 1'b1;
            doe_d  = 1'b0;
            if (i_cs) begin
               we_d = i_we;
               if (is_bank) begin
                  // Register access: no SRAM cycle, straight to ACK.
                  state_d = ACK;
                  ack_d   = 1'b1;
`ifdef SRAM_RESPONDER_BANK_EN
                  if (i_we) bank_d = i_dat[1:0];
                  else      rdat_d = {6'b0, bank_q};
`endif
               end else begin
                  state_d = SETUP;
                  saddr_d = mapped_addr;
                  cs_n_d  = 1'b0;
                  cnt_d   = WAIT_INIT;
                  if (i_we) begin
                     sdat_d = i_dat;
                     doe_d  = 1'b1;
                  end else begin
                     oe_n_d = 1'b0;
                  end
               end
            end
         end
         SETUP: begin
            // Address and data have had a cycle to settle; now pulse we_n for writes.
            state_d = ACCESS;
            if (we_q) we_n_d = 1'b0;
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ACK;
               ack_d   = 1'b1;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               if (!we_q) rdat_d = i_sram_dat;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            // cs_n, address and write data were held through this cycle for hold time.
            state_d = IDLE;
            cs_n_d  = 1'b1;
            doe_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access without an ack.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         rdat_q  <= 8'h00;
         saddr_q <= 18'h0;
         sdat_q  <= 8'h00;
         doe_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         saddr_q <= saddr_d;
         sdat_q  <= sdat_d;
         doe_q   <= doe_d;
         cs_n_q  <= cs_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
      end
   end

`ifdef SRAM_RESPONDER_BANK_EN
   // Bank register, cleared by reset.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) bank_q <= 2'b00;
      else            bank_q <= bank_d;
   end
`endif

   assign o_ack         = ack_q;
   assign o_dat         = rdat_q;
   assign o_sram_addr   = saddr_q;
   assign o_sram_dat    = sdat_q;
   assign o_sram_dat_oe = doe_q;
   assign o_sram_cs_n   = cs_n_q;
   assign o_sram_oe_n   = oe_n_q;
   assign o_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: random and directed accesses against a behavioural SRAM and reference memory.
// Checks latency, strobe widths, addresses, read data and reset behaviour.
// Initiator holds the request until o_ack and drops i_cs in the ack cycle.
module tb_sram_responder;

   localparam int          W     = 1;
   localparam logic [15:0] BADDR = 16'hFFFF;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic [15:0] i_addr = '0;
   logic [7:0]  i_dat = '0;
   logic [7:0]  o_dat;
   logic        i_we = 1'b0;
   logic        i_cs = 1'b0;
   logic        o_ack;
   logic [17:0] o_sram_addr;
   logic [7:0]  o_sram_dat;
   logic        o_sram_dat_oe;
   logic [7:0]  i_sram_dat;
   logic        o_sram_cs_n;
   logic        o_sram_oe_n;
   logic        o_sram_we_n;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int sram_acc = 0;
   logic in_txn = 1'b0;

   logic [7:0] sram_mem [0:262143];
   logic [7:0] ref_mem [logic [17:0]];
   logic [1:0] ref_bank = 2'b00;

   sram_responder #(.WAIT_CYCLES(W), .BANK_ADDR(BADDR)) u_dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat),
      .i_we(i_we), .i_cs(i_cs), .o_ack(o_ack), .o_sram_addr(o_sram_addr),
      .o_sram_dat(o_sram_dat), .o_sram_dat_oe(o_sram_dat_oe), .i_sram_dat(i_sram_dat),
      .o_sram_cs_n(o_sram_cs_n), .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Behavioural asynchronous SRAM.
   assign i_sram_dat = (!o_sram_cs_n && !o_sram_oe_n) ? sram_mem[o_sram_addr] : 8'hEE;
   always @(posedge i_clk) if (!o_sram_cs_n && !o_sram_we_n) sram_mem[o_sram_addr] <= o_sram_dat;
   always @(negedge o_sram_cs_n) if (i_reset_n) sram_acc <= sram_acc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Strobes idle whenever no transaction is outstanding; we_n/oe_n never both low.
   always @(posedge i_clk) begin
      #2;
      if (i_reset_n) begin
         check("we_oe_excl", {31'b0, !(!o_sram_we_n && !o_sram_oe_n)}, 32'd1);
         if (!in_txn)
            check("idle_strobes", {28'b0, o_sram_cs_n, o_sram_oe_n, o_sram_we_n, o_sram_dat_oe}, 32'b1110);
      end
   end

   function automatic logic [17:0] map_addr(input logic [15:0] a);
`ifdef SRAM_RESPONDER_BANK_EN
      return a[15] ? {ref_bank, a} : {2'b00, a};
`else
      return {2'b00, a};
`endif
   endfunction

   function automatic logic is_bank_addr(input logic [15:0] a);
`ifdef SRAM_RESPONDER_BANK_EN
      return a == BADDR;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] ref_rd(input logic [17:0] ea);
      return ref_mem.exists(ea) ? ref_mem[ea] : 8'h00;
   endfunction

   task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         output logic [7:0] rdat, output int ack_cyc, output logic [17:0] obs_addr);
      int lat, we_lo, oe_lo, cs_lo, doe_hi, exp_lat;
      logic bank;
      logic [17:0] ea;
      logic [7:0] exp_rd;
      bank    = is_bank_addr(addr);
      ea      = map_addr(addr);
      exp_rd  = bank ? {6'b0, ref_bank} : ref_rd(ea);
      exp_lat = bank ? 1 : 3 + W;
      lat = 0; we_lo = 0; oe_lo = 0; cs_lo = 0; doe_hi = 0;
      rdat = 8'h00; ack_cyc = 0; obs_addr = 18'h0;
      @(negedge i_clk);
      i_cs = 1'b1; i_we = we; i_addr = addr; i_dat = wd; in_txn = 1'b1;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(posedge i_clk); #1;
         if (!o_sram_we_n) we_lo++;
         if (!o_sram_oe_n) oe_lo++;
         if (!o_sram_cs_n) cs_lo++;
         if (o_sram_dat_oe) doe_hi++;
         if (c == 1) obs_addr = o_sram_addr;
         if (c == 1 && !bank) check("setup_addr", {14'b0, o_sram_addr}, {14'b0, ea});
         if (o_ack) begin
            lat = c;
            ack_cyc = cyc;
            rdat = o_dat;
            if (we && !bank) begin
               check("ack_wdat", {24'b0, o_sram_dat}, {24'b0, wd});
               check("ack_wdat_oe", {31'b0, o_sram_dat_oe}, 32'd1);
            end
         end
      end
      check("latency", lat, exp_lat);
      check("we_n_low_cycles", we_lo, (we && !bank) ? W + 1 : 0);
      check("oe_n_low_cycles", oe_lo, (!we && !bank) ? W + 2 : 0);
      check("cs_n_low_cycles", cs_lo, bank ? 0 : 3 + W);
      check("dat_oe_cycles", doe_hi, (we && !bank) ? 3 + W : 0);
      if (!we) check("read_data", {24'b0, rdat}, {24'b0, exp_rd});
      if (we) begin
         if (bank) ref_bank = wd[1:0];
         else ref_mem[ea] = wd;
      end
      @(negedge i_clk);
      i_cs = 1'b0; in_txn = 1'b0;
      @(posedge i_clk); #1;
      check("ack_one_cycle", {31'b0, o_ack}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      int a1, a2, acc0;
      logic [17:0] oa;
      for (int i = 0; i < 262144; i++) sram_mem[i] = 8'h00;

      // Reset state.
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_strobes", {29'b0, o_sram_cs_n, o_sram_oe_n, o_sram_we_n}, 32'b111);
      check("rst_ack", {31'b0, o_ack}, 32'd0);
      check("rst_odat", {24'b0, o_dat}, 32'd0);
      check("rst_saddr", {14'b0, o_sram_addr}, 32'd0);
      check("rst_sdat_oe", {23'b0, o_sram_dat_oe, o_sram_dat}, 32'd0);
      @(negedge i_clk);
      i_reset_n = 1'b1;

      // Directed write then read.
      access(1'b1, 16'h1234, 8'hA5, rd, a1, oa);
      check("wr_1234_addr", {14'b0, oa}, 32'h01234);
      sram_mem[18'h00042] = 8'h3C;
      ref_mem[18'h00042]  = 8'h3C;
      access(1'b0, 16'h0042, 8'h00, rd, a1, oa);
      check("rd_0042_data", {24'b0, rd}, 32'h3C);
      access(1'b1, 16'h0050, 8'h77, rd, a1, oa);
      check("odat_held", {24'b0, o_dat}, 32'h3C);
      access(1'b0, 16'h1234, 8'h00, rd, a1, oa);

      // Back-to-back reads, i_cs low only in the ack cycle.
      acc0 = sram_acc;
      access(1'b0, 16'h0042, 8'h00, rd, a1, oa);
      access(1'b0, 16'h0050, 8'h00, rd, a2, oa);
      check("b2b_ack_gap", a2 - a1, W + 4);
      check("b2b_sram_accesses", sram_acc - acc0, 2);

`ifdef SRAM_RESPONDER_BANK_EN
      access(1'b1, 16'hFFFF, 8'h02, rd, a1, oa);
      access(1'b0, 16'h8001, 8'h00, rd, a1, oa);
      check("bank_addr_8001", {14'b0, oa}, 32'h28001);
      access(1'b0, 16'h0001, 8'h00, rd, a1, oa);
      check("bank_addr_0001", {14'b0, oa}, 32'h00001);
      access(1'b1, 16'hFFFF, 8'h03, rd, a1, oa);
      access(1'b0, 16'hFFFF, 8'h00, rd, a1, oa);
      check("bank_read", {24'b0, rd}, 32'h03);
`endif

      // Randomized traffic against the reference memory.
      for (int t = 0; t < 60; t++) begin
         logic [15:0] ad;
         ad = ($urandom_range(0, 1) ? 16'h8000 : 16'h0000) | 16'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) ad = BADDR;
         access(1'($urandom_range(0, 1)), ad, 8'($urandom), rd, a1, oa);
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
      end

      // Reset in the middle of a write access.
      @(negedge i_clk);
      i_cs = 1'b1; i_we = 1'b1; i_addr = 16'h2345; i_dat = 8'h5A; in_txn = 1'b1;
      repeat (2) @(posedge i_clk);
      #3;
      check("pre_rst_we_low", {31'b0, o_sram_we_n}, 32'd0);
      i_reset_n = 1'b0;
      #1;
      check("midrst_strobes", {29'b0, o_sram_cs_n, o_sram_oe_n, o_sram_we_n}, 32'b111);
      check("midrst_dat_oe", {31'b0, o_sram_dat_oe}, 32'd0);
      check("midrst_ack", {31'b0, o_ack}, 32'd0);
      i_cs = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk); #1;
         check("midrst_no_ack", {31'b0, o_ack}, 32'd0);
      end
      check("midrst_odat", {24'b0, o_dat}, 32'd0);
      check("midrst_saddr", {14'b0, o_sram_addr}, 32'd0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      in_txn = 1'b0;
      ref_bank = 2'b00;
      for (int k = 0; k < 4; k++) begin
         @(posedge i_clk); #1;
         check("post_rst_no_ack", {31'b0, o_ack}, 32'd0);
      end
      access(1'b0, 16'h0042, 8'h00, rd, a1, oa);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
